// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: format codes, opcodes, immediate range limits and the
// encoder's FSM state type.
package riscv_pkg;

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_SHAMT = 3'd2;
  localparam logic [2:0] FMT_S     = 3'd3;
  localparam logic [2:0] FMT_B     = 3'd4;
  localparam logic [2:0] FMT_U     = 3'd5;
  localparam logic [2:0] FMT_J     = 3'd6;
  localparam logic [2:0] FMT_LI    = 3'd7;

  localparam logic [6:0]  OP_LUI   = 7'h37;
  localparam logic [6:0]  OP_OPIMM = 7'h13;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -(1 << 20);
  localparam int IMM21_MAX = (1 << 20) - 2;

  typedef enum logic [0:0] {
    StIdle,
    StSecond
  } state_e;

  function automatic logic in_range(logic [31:0] v, int lo, int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with per-format immediate range/alignment check.
// The word is always built from the truncated immediate bits, even when err_o is set.
module instr_pack
  import riscv_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  logic range_err;

  always_comb begin
    word_o    = INSTR_NOP;
    range_err = 1'b0;
    case (fmt_i)
      FMT_R: begin
        word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      end
      FMT_I: begin
        word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        range_err = !in_range(imm_i, IMM12_MIN, IMM12_MAX);
      end
      FMT_SHAMT: begin
        word_o    = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
        range_err = |imm_i[31:5];
      end
      FMT_S: begin
        word_o    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        range_err = !in_range(imm_i, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                     opcode_i};
        range_err = !in_range(imm_i, IMM13_MIN, IMM13_MAX) || imm_i[0];
      end
      FMT_U: begin
        word_o    = {imm_i[31:12], rd_i, opcode_i};
        range_err = |imm_i[11:0];
      end
      FMT_J: begin
        word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        range_err = !in_range(imm_i, IMM21_MIN, IMM21_MAX) || imm_i[0];
      end
      default: begin
        // LI never reaches the packer unexpanded unless expansion is disabled.
        word_o = INSTR_NOP;
      end
    endcase
  end

  assign err_o = CHECK_EN & range_err;

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with LI pseudo-instruction expansion (LUI/ADDI) and a
// registered valid/ready output stage.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter bit LI_EN    = 1'b1,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err
);

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_err_q, pend_err_d;

  logic        is_li, li_small, need_second, accept, drain;
  logic [19:0] li_hi;
  logic [2:0]  a_fmt;
  logic [6:0]  a_opcode;
  logic [4:0]  a_rs1;
  logic [2:0]  a_funct3;
  logic [31:0] a_imm, a_word, b_word;
  logic        a_err, b_err;

  assign is_li    = LI_EN && (fmt == FMT_LI);
  assign li_small = in_range(imm, IMM12_MIN, IMM12_MAX);
  // (imm + 0x800)[31:12]: the carry out of the low 12 bits is exactly imm[11].
  assign li_hi    = imm[31:12] + {19'b0, imm[11]};

  always_comb begin
    a_fmt       = fmt;
    a_opcode    = opcode;
    a_rs1       = rs1;
    a_funct3    = funct3;
    a_imm       = imm;
    need_second = 1'b0;
    if (is_li) begin
      if (li_small) begin
        a_fmt    = FMT_I;
        a_opcode = OP_OPIMM;
        a_rs1    = 5'd0;
        a_funct3 = 3'd0;
      end else begin
        a_fmt       = FMT_U;
        a_opcode    = OP_LUI;
        a_imm       = {li_hi, 12'h000};
        need_second = (imm[11:0] != 12'h000);
      end
    end
  end

  instr_pack #(
    .CHECK_EN (CHECK_EN)
  ) u_pack_first (
    .fmt_i    (a_fmt),
    .opcode_i (a_opcode),
    .rd_i     (rd),
    .rs1_i    (a_rs1),
    .rs2_i    (rs2),
    .funct3_i (a_funct3),
    .funct7_i (funct7),
    .imm_i    (a_imm),
    .word_o   (a_word),
    .err_o    (a_err)
  );

  // Second LI word: ADDI rd, rd, lo with lo sign-extended.
  instr_pack #(
    .CHECK_EN (CHECK_EN)
  ) u_pack_second (
    .fmt_i    (FMT_I),
    .opcode_i (OP_OPIMM),
    .rd_i     (rd),
    .rs1_i    (rd),
    .rs2_i    (5'd0),
    .funct3_i (3'd0),
    .funct7_i (7'd0),
    .imm_i    ({{20{imm[11]}}, imm[11:0]}),
    .word_o   (b_word),
    .err_o    (b_err)
  );

  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    pend_d      = pend_q;
    pend_err_d  = pend_err_q;
    if (drain) begin
      out_valid_d = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          out_valid_d = 1'b1;
          instr_d     = a_word;
          err_d       = a_err | (!LI_EN && (fmt == FMT_LI));
          if (need_second) begin
            pend_d     = b_word;
            pend_err_d = b_err;
            state_d    = StSecond;
          end
        end
      end
      StSecond: begin
        if (drain) begin
          out_valid_d = 1'b1;
          instr_d     = pend_q;
          err_d       = pend_err_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      instr_q     <= 32'h0;
      err_q       <= 1'b0;
      pend_q      <= 32'h0;
      pend_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      pend_err_q  <= pend_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued when requests are driven
// and compared as the encoder hands them downstream.
module tb_instr_encoder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] instr;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  instr_encoder dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic expect_word(input logic [31:0] w, input logic e);
    exp_q.push_back({w, e});
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send();
    in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
    check_val("send_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clock);
    #1;
    check_val("drain_empty", exp_q.size(), 32'd0);
    check_val("drain_valid", {31'b0, out_valid}, 32'd0);
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("sb_underflow", exp_q.size(), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("sb_instr", instr, mon_e[32:1]);
        check_val("sb_err", {31'b0, err}, {31'b0, mon_e[0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #2;
    check_val("rst_valid", {31'b0, out_valid}, 32'd0);
    check_val("rst_instr", instr, 32'd0);
    check_val("rst_err", {31'b0, err}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_val("rst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clock); #1;

    // I-type with one-cycle latency
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    expect_word(32'h0050_0093, 1'b0);
    send();
    check_val("lat_valid", {31'b0, out_valid}, 32'd1);
    check_val("lat_instr", instr, 32'h0050_0093);
    wait_drain();

    // B-type: in range, misaligned, out of range
    set_req(3'd4, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    expect_word(32'h0020_8463, 1'b0);
    send();
    imm = 32'd7;
    expect_word(32'h0020_8363, 1'b1);
    send();
    imm = 32'd4096;
    expect_word(32'h8020_8063, 1'b1);
    send();
    // J, R, S, SHAMT, U
    set_req(3'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    expect_word(32'h0010_00EF, 1'b0);
    send();
    set_req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    expect_word(32'h0020_81B3, 1'b0);
    send();
    set_req(3'd3, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFF_FFFC);
    expect_word(32'hFE31_2E23, 1'b0);
    send();
    set_req(3'd2, 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32);
    expect_word(32'h0000_9093, 1'b1);
    send();
    set_req(3'd5, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    expect_word(32'h1234_5137, 1'b1);
    send();
    wait_drain();

    // LI two words with backpressure on word 1
    out_ready = 1'b0;
    set_req(3'd7, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    expect_word(32'h1234_62B7, 1'b0);
    expect_word(32'hFFF2_8293, 1'b0);
    send();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_val("li_hold_instr", instr, 32'h1234_62B7);
      check_val("li_hold_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_drain();

    // LI single-word forms
    set_req(3'd7, 7'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
    expect_word(32'h0000_10B7, 1'b0);
    send();
    imm = 32'hFFFF_FFFF;
    expect_word(32'hFFF0_0093, 1'b0);
    send();
    wait_drain();

    // Back-to-back I-type, no bubbles
    for (int i = 0; i < 8; i++) begin
      logic [31:0] v;
      v = 32'(i * 300 - 700);
      set_req(3'd1, 7'h13, 5'(i + 1), 5'(i), 5'd0, 3'(i), 7'd0, v);
      expect_word({v[11:0], 5'(i), 3'(i), 5'(i + 1), 7'h13}, 1'b0);
      in_valid = 1'b1;
      @(negedge clock);
      check_val("b2b_ready", {31'b0, in_ready}, 32'd1);
      if (i > 0) check_val("b2b_valid", {31'b0, out_valid}, 32'd1);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    wait_drain();

    // Reset while the LI second word is pending
    out_ready = 1'b0;
    set_req(3'd7, 7'd0, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    send();
    @(negedge clock);
    check_val("pre_rst_ready", {31'b0, in_ready}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check_val("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check_val("mid_rst_instr", instr, 32'd0);
    @(posedge clock); #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_val("no_stale_valid", {31'b0, out_valid}, 32'd0);
      check_val("post_rst_ready", {31'b0, in_ready}, 32'd1);
    end

    check_val("sb_final_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate decoder: packs opcode, register, funct and immediate fields into a 32-bit RV32I instruction word.
- Expands the LI pseudo-instruction into one or two words (LUI/ADDI).
- Checks immediate range and alignment for each format.
- Sits between the test/program generator or boot-ROM builder and instruction memory; valid/ready on both sides, registered output.

Parameters:
- LI_EN, 1, enables LI expansion (fmt 7); when 0, fmt 7 emits 32'h00000013 (NOP) with err=1.
- CHECK_EN, 1, enables range/alignment checking; when 0, err is always 0.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- fmt  in  3  0=R 1=I 2=SHAMT 3=S 4=B 5=U 6=J 7=LI
- opcode  in  7  instr[6:0]; ignored for LI
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25] (R, SHAMT)
- imm  in  32  byte-offset/value immediate, two's complement
- out_valid  out  1  instr/err valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- instr  out  32  encoded instruction
- err  out  1  immediate out of range or misaligned for this word

Behaviour:
- Reset (async, reset_n=0): state=S_IDLE, out_valid=0, instr=0, err=0, pending word cleared. Takes effect immediately, including mid-LI; the pending second word is discarded.
- in_ready = (state==S_IDLE) && (!out_valid || out_ready). This is combinational and gives full throughput for single-word formats.
- Latency: accept at edge N gives out_valid=1 with the word after edge N. While out_valid && !out_ready, instr and err hold stable.
- Drain with no new accept: out_valid -> 0.
- Encoding, per the RV32I spec:
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I: {imm[11:0],rs1,funct3,rd,opcode}
  - SHAMT: {funct7,imm[4:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U: {imm[31:12],rd,opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- err conditions, with CHECK_EN=1:
  - I/S: imm outside [-2048,2047]
  - SHAMT: imm[31:5]!=0
  - B: imm outside [-4096,4094] or imm[0]=1
  - J: imm outside [-2^20, 2^20-2] or imm[0]=1
  - U: imm[11:0]!=0
  - R/LI: never
  - On err, the word is still emitted using the truncated bits above.
- LI expansion:
  - lo = imm[11:0]; hi = (imm + 32'h800)[31:12].
  - If imm in [-2048,2047]: one word, ADDI rd,x0,lo (opcode 7'h13, funct3 0).
  - Else if lo==0: one word, LUI rd,hi (opcode 7'h37).
  - Else: two words, LUI rd,hi then ADDI rd,rd,lo.
- FSM states:
  - S_IDLE: on accept, load word 1 into the output register. If a second word is needed, latch it into the pending register and go to S_SECOND.
  - S_SECOND: in_ready=0. When out_valid && out_ready, load the pending word and go to S_IDLE. Word 2 is never emitted before word 1 drains.
- rd=x0 is not special-cased; it is encoded as given.
- All arithmetic is 32-bit and wraps. Overflow in imm+0x800 is ignored; this is consistent with the hardware's LUI+ADDI sum.

Decomposition:
- Shared package riscv_pkg:
  - fmt codes FMT_R..FMT_LI
  - opcode constants OP_LUI=7'h37, OP_OPIMM=7'h13
  - range limits per format
- Sub-module instr_pack: purely combinational field packer plus range checker (fmt, fields, imm -> word, err). instr_encoder instantiates it twice: once for the input request and once for the LI second word at latch time.

Test Plan:
- I: fmt=1, opcode=13, rd=1, rs1=0, funct3=0, imm=5 -> instr=32'h00500093, err=0, one cycle after accept.
- B: fmt=4, opcode=63, rs1=1, rs2=2, imm=8 -> 32'h00208463. Then imm=7 -> err=1. Then imm=4096 -> err=1.
- J: fmt=6, opcode=6F, rd=1, imm=2048 -> 32'h001000EF, err=0.
- LI two words: rd=5, imm=32'h12345FFF -> 32'h123462B7 then 32'hFFF28293. in_ready=0 between the two words. Hold out_ready=0 for 3 cycles and check that word 1 stays stable.
- LI single: rd=1, imm=32'h00001000 -> only 32'h000010B7. Back-to-back I-type requests with out_ready=1 -> one word per cycle, no bubbles.
- Reset: deassert reset_n while in S_SECOND -> out_valid=0 immediately. After release, in_ready=1 and no stale second word appears.
